instr_encoder: RTL
==================

Name: instr_encoder

Overview:
- Inverse of the control decoder: takes symbolic instruction requests (class, ALU op, register numbers, immediate/target) and encodes them into 32-bit instruction words in the same ISA the control unit decodes.
- Encoded words are buffered in a small FIFO and emitted on a valid/ready write port with an auto-incrementing instruction-memory address.
- Used as the program loader / self-test stimulus generator feeding instruction memory.

Parameters:
- DEPTH, 4, FIFO entries, power of two, ≥2.
- ADDR_W, 32, width of the emitted address.
- BASE_ADDR, 0, address of the first word after reset or clear.
- ADDR_STEP, 4, address increment per accepted output word (byte addressing).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- clear  in  1  sync flush: empties FIFO, addr:=BASE_ADDR, err_sticky:=0, word_count:=0.
- in_valid  in  1  request valid.
- in_ready  out  1  = !full.
- in_kind  in  4  0 R-ALU, 1 JR, 2 I-ALU, 3 LW, 4 SW, 5 BR, 6 J, 7 JAL, 8-15 illegal.
- in_aluop  in  3  ALU op for R-ALU / I-ALU.
- in_rs, in_rt, in_rd  in  5 each  register numbers.
- in_imm  in  16  immediate / offset.
- in_target  in  26  jump target field.
- out_valid  out  1  = !empty.
- out_ready  in  1  consumer accepts word.
- out_addr  out  ADDR_W  address for the head word.
- out_data  out  32  encoded head word.
- err  out  1  one-cycle pulse, cycle after an illegal kind is accepted.
- err_sticky  out  1  set by any illegal kind; cleared only by rst/clear.
- word_count  out  16  words emitted since reset/clear, wraps at 2^16.

Behaviour:
- Encoding (fields opcode[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6]=0, func[5:0]):
  - R-ALU: opcode 0, rs, rt, rd, func = {3'b000, aluop}.
  - JR: opcode 0, rs, rt=rd=shamt=0, func 6'b001000.
  - I-ALU: opcode {3'b010, aluop}, rs, rt, imm.
  - LW: opcode 6'b100011, rs, rt, imm.
  - SW: 6'b101011, rs, rt, imm.
  - BR: 6'b110000, rs, rt, imm.
  - J: 6'b110001, target.
  - JAL: 6'b110011, target.
  - Unused input fields are ignored (e.g. rd for I-type, aluop for LW).
- Push: in_valid && in_ready. Legal kind → encoded word written at tail. Illegal kind → handshake completes, nothing pushed, err=1 next cycle, err_sticky=1.
- Pop: out_valid && out_ready → head removed, out_addr += ADDR_STEP (wraps modulo 2^ADDR_W), word_count += 1.
- Latency: word pushed into empty FIFO appears on out_valid/out_data the next cycle. No combinational in→out path.
- in_ready depends only on registered occupancy. Pop while full does not raise in_ready in the same cycle.
- Simultaneous push and pop (non-empty, non-full): occupancy unchanged, order preserved.
- Pointer wrap: read/write pointers wrap modulo DEPTH. Full/empty are distinguished by a count or an extra pointer bit.
- out_data and out_addr are stable while out_valid && !out_ready.
- clear has priority over a same-cycle push/pop. Both are ignored that cycle and in_ready stays at its pre-clear value. An illegal kind presented with clear raises neither err nor err_sticky.
- Reset values (rst, including mid-stream): FIFO empty, out_valid=0, in_ready=1, out_addr=BASE_ADDR, out_data=0, err=0, err_sticky=0, word_count=0. Pending words are discarded.

Test Plan:
- R-ALU aluop=3, rs=1, rt=2, rd=3, out_ready=1 → next cycle out_valid=1, out_data=0x00221803, out_addr=0x0; then word_count=1.
- Sequence: I-ALU aluop=0, rs=4, rt=5, imm=0x1234; LW rs=29, rt=8, imm=0x0010; JR rs=31; JAL target=0x40 → out_data 0x40851234, 0x8FA80010, 0x03E00008, 0xCC000040 at out_addr 0x0, 0x4, 0x8, 0xC.
- Backpressure: out_ready=0, push 5 legal requests → in_ready=0 after the 4th, 5th held; raise out_ready → all 5 words emitted in order, addresses 0x0 through 0x10.
- Illegal kind=9 between two legal pushes → err pulses exactly once, err_sticky=1, only 2 words emitted, addresses contiguous (0x0, 0x4).
- Assert clear with 3 words queued → next cycle out_valid=0, out_addr=0, word_count=0, err_sticky=0; subsequent push is emitted at 0x0.
- rst asserted mid-stream with FIFO full → all outputs at reset values next cycle; no stale word is emitted afterwards.

Source files
------------

// File: rtl/instr_encoder.sv
// Encodes symbolic instruction requests into 32-bit ISA words and queues them
// in a small FIFO that drains onto an auto-addressed instruction-memory write port.
module instr_encoder #(
  parameter int                 DEPTH     = 4,
  parameter int                 ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
  parameter int                 ADDR_STEP = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_kind,
  input  logic [2:0]        in_aluop,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_data,
  output logic              err,
  output logic              err_sticky,
  output logic [15:0]       word_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  function automatic logic [31:0] encode(
    input logic [3:0]  kind,
    input logic [2:0]  aluop,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [15:0] imm,
    input logic [25:0] target
  );
    logic [31:0] word;
    word = '0;
    case (kind)
      4'd0:    word = {6'b000000, rs, rt, rd, 5'd0, 3'b000, aluop};
      4'd1:    word = {6'b000000, rs, 5'd0, 5'd0, 5'd0, 6'b001000};
      4'd2:    word = {3'b010, aluop, rs, rt, imm};
      4'd3:    word = {6'b100011, rs, rt, imm};
      4'd4:    word = {6'b101011, rs, rt, imm};
      4'd5:    word = {6'b110000, rs, rt, imm};
      4'd6:    word = {6'b110001, target};
      4'd7:    word = {6'b110011, target};
      default: word = '0;
    endcase
    return word;
  endfunction

  logic [31:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [31:0]      word_p0;
  logic             push;
  logic             push_legal;
  logic             pop;
  logic             flush;

  // Stage p0: request decode and handshake qualification
  assign in_ready   = (count != CNT_W'(DEPTH));
  assign out_valid  = (count != '0);
  assign push       = in_valid && in_ready;
  assign push_legal = push && !in_kind[3];
  assign pop        = out_valid && out_ready;
  assign flush      = rst || clear;
  assign word_p0    = encode(in_kind, in_aluop, in_rs, in_rt, in_rd, in_imm, in_target);

  // An empty FIFO presents zero so the word port shows nothing stale
  assign out_data = out_valid ? mem[rd_ptr] : '0;

  // Stage p1: FIFO storage, pointers, address and status registers
  always_ff @(posedge clk) begin
    if (!flush && push_legal) begin
      mem[wr_ptr] <= word_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      out_addr   <= BASE_ADDR;
      err        <= 1'b0;
      err_sticky <= 1'b0;
      word_count <= '0;
    end else begin
      err <= push && in_kind[3];
      if (push && in_kind[3]) begin
        err_sticky <= 1'b1;
      end
      if (push_legal) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr     <= rd_ptr + PTR_W'(1);
        out_addr   <= out_addr + ADDR_W'(ADDR_STEP);
        word_count <= word_count + 16'd1;
      end
      case ({push_legal, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
